// File: rtl/mux_tree_arbiter.sv
// Round-robin arbiter driving the select bus and one-hot grant of a shared N_REQ:1 mux tree.
// Optional forced release after MAX_HOLD grant cycles is built in when MUX_ARB_TIMEOUT_EN is defined.
module mux_tree_arbiter #(
    parameter int N_REQ    = 4,
    parameter int SEL_W    = $clog2(N_REQ),
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_valid
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [SEL_W-1:0] sel_reg;
    logic [SEL_W-1:0] last_reg;
    logic             gnt_valid_reg;

    logic [N_REQ-1:0] rot_req;
    logic [SEL_W-1:0] pick_off;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             timeout;

    // rot_req[k] is the requester k+1 places after the last grantee; N_REQ is a power of 2,
    // so the SEL_W-bit sum wraps modulo N_REQ for free.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_req[gi] = req[last_reg + SEL_W'(gi + 1)];
        end
    endgenerate

    always_comb begin
        pick_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_off = SEL_W'(k);
            end
        end
    end

    assign pick_idx    = last_reg + pick_off + SEL_W'(1);
    assign pick_onehot = N_REQ'(1) << pick_idx;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_cnt_reg;

    assign timeout = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            hold_cnt_reg <= '0;
        end else if (!timeout) begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Leaving GRANT always passes through IDLE for one cycle, giving the tree a settling gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            sel_reg       <= '0;
            last_reg      <= SEL_W'(N_REQ - 1);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        state_reg     <= GRANT;
                        gnt_reg       <= pick_onehot;
                        gnt_valid_reg <= 1'b1;
                        sel_reg       <= pick_idx;
                        last_reg      <= pick_idx;
                    end
                end
                default: begin
                    if (!req[last_reg] || timeout) begin
                        state_reg     <= IDLE;
                        gnt_reg       <= '0;
                        gnt_valid_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign sel       = sel_reg;
    assign gnt_valid = gnt_valid_reg;

endmodule
